// File: rtl/axi_err_slv_term_pkg.sv
// rtl/axi_err_slv_term_pkg.sv - AXI channel structs and response codes for the error slave
package axi_err_slv_term_pkg;

   localparam int unsigned ID_W   = 4;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned USER_W = 1;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        len;
      logic [2:0]        size;
      logic [1:0]        burst;
   } ax_chan_t;

   typedef struct packed {
      logic [DATA_W-1:0]   data;
      logic [DATA_W/8-1:0] strb;
      logic                last;
   } w_chan_t;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [1:0]        resp;
      logic [USER_W-1:0] user;
   } b_chan_t;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [DATA_W-1:0] data;
      logic [1:0]        resp;
      logic              last;
      logic [USER_W-1:0] user;
   } r_chan_t;

   typedef struct packed {
      ax_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ax_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      logic    b_valid;
      b_chan_t b;
      logic    r_valid;
      r_chan_t r;
   } resp_t;

endpackage

// File: rtl/axi_err_slv_term.sv
// rtl/axi_err_slv_term.sv - AXI4 terminating slave answering every transaction with DECERR
module axi_err_slv_term
   import axi_err_slv_term_pkg::*;
#(
   parameter int unsigned IdWidth   = ID_W,
   parameter int unsigned DataWidth = DATA_W,
   parameter logic [63:0] RespData  = 64'hDEAD_BEEF_DEAD_BEEF,
   parameter type         req_t     = axi_err_slv_term_pkg::req_t,
   parameter type         resp_t    = axi_err_slv_term_pkg::resp_t
) (
   input  logic  clk_i,
   input  logic  rst_i,
   input  req_t  slv_req_i,
   output resp_t slv_resp_o
);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

   w_state_e             w_state_q, w_state_d;
   logic                 aw_ready_q, aw_ready_d;
   logic                 w_ready_q, w_ready_d;
   logic                 b_valid_q, b_valid_d;
   logic [IdWidth-1:0]   b_id_q, b_id_d;

   r_state_e             r_state_q, r_state_d;
   logic                 ar_ready_q, ar_ready_d;
   logic                 r_valid_q, r_valid_d;
   logic                 r_last_q, r_last_d;
   logic [IdWidth-1:0]   r_id_q, r_id_d;
   logic [7:0]           r_len_q, r_len_d;
   logic [7:0]           r_cnt_q, r_cnt_d;

   // Address, size, data and strobe are irrelevant to a terminator.
   logic unused_req;
   assign unused_req = ^slv_req_i;

   always_comb begin
      w_state_d  = w_state_q;
      aw_ready_d = aw_ready_q;
      w_ready_d  = w_ready_q;
      b_valid_d  = b_valid_q;
      b_id_d     = b_id_q;
      unique case (w_state_q)
         W_IDLE: if (slv_req_i.aw_valid) begin
            b_id_d     = slv_req_i.aw.id;
            aw_ready_d = 1'b0;
            w_ready_d  = 1'b1;
            w_state_d  = W_DATA;
         end
         W_DATA: if (slv_req_i.w_valid && slv_req_i.w.last) begin
            w_ready_d = 1'b0;
            b_valid_d = 1'b1;
            w_state_d = W_RESP;
         end
         W_RESP: if (slv_req_i.b_ready) begin
            b_valid_d  = 1'b0;
            aw_ready_d = 1'b1;
            w_state_d  = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // r_last is precomputed one beat ahead so the R payload leaves straight from flops.
   always_comb begin
      r_state_d  = r_state_q;
      ar_ready_d = ar_ready_q;
      r_valid_d  = r_valid_q;
      r_last_d   = r_last_q;
      r_id_d     = r_id_q;
      r_len_d    = r_len_q;
      r_cnt_d    = r_cnt_q;
      unique case (r_state_q)
         R_IDLE: if (slv_req_i.ar_valid) begin
            r_id_d     = slv_req_i.ar.id;
            r_len_d    = slv_req_i.ar.len;
            r_cnt_d    = 8'd0;
            r_last_d   = (slv_req_i.ar.len == 8'd0);
            r_valid_d  = 1'b1;
            ar_ready_d = 1'b0;
            r_state_d  = R_DATA;
         end
         R_DATA: if (slv_req_i.r_ready) begin
            if (r_last_q) begin
               r_valid_d  = 1'b0;
               r_last_d   = 1'b0;
               ar_ready_d = 1'b1;
               r_state_d  = R_IDLE;
            end else begin
               r_cnt_d  = r_cnt_q + 8'd1;
               r_last_d = ((r_cnt_q + 8'd1) == r_len_q);
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         w_state_q  <= W_IDLE;
         aw_ready_q <= 1'b1;
         w_ready_q  <= 1'b0;
         b_valid_q  <= 1'b0;
         b_id_q     <= '0;
         r_state_q  <= R_IDLE;
         ar_ready_q <= 1'b1;
         r_valid_q  <= 1'b0;
         r_last_q   <= 1'b0;
         r_id_q     <= '0;
         r_len_q    <= 8'd0;
         r_cnt_q    <= 8'd0;
      end else begin
         w_state_q  <= w_state_d;
         aw_ready_q <= aw_ready_d;
         w_ready_q  <= w_ready_d;
         b_valid_q  <= b_valid_d;
         b_id_q     <= b_id_d;
         r_state_q  <= r_state_d;
         ar_ready_q <= ar_ready_d;
         r_valid_q  <= r_valid_d;
         r_last_q   <= r_last_d;
         r_id_q     <= r_id_d;
         r_len_q    <= r_len_d;
         r_cnt_q    <= r_cnt_d;
      end
   end

   always_comb begin
      slv_resp_o          = '0;
      slv_resp_o.aw_ready = aw_ready_q;
      slv_resp_o.w_ready  = w_ready_q;
      slv_resp_o.b_valid  = b_valid_q;
      slv_resp_o.b.id     = b_id_q;
      slv_resp_o.b.resp   = b_valid_q ? AXI_RESP_DECERR : AXI_RESP_OKAY;
      slv_resp_o.ar_ready = ar_ready_q;
      slv_resp_o.r_valid  = r_valid_q;
      slv_resp_o.r.id     = r_id_q;
      slv_resp_o.r.data   = r_valid_q ? RespData[DataWidth-1:0] : '0;
      slv_resp_o.r.resp   = r_valid_q ? AXI_RESP_DECERR : AXI_RESP_OKAY;
      slv_resp_o.r.last   = r_last_q;
   end

endmodule

// File: tb/tb_axi_err_slv_term.sv
// tb/tb_axi_err_slv_term.sv - directed self-checking bench for axi_err_slv_term
module tb_axi_err_slv_term;
   import axi_err_slv_term_pkg::*;

   localparam logic [63:0] DATA_EXP = 64'hDEAD_BEEF_DEAD_BEEF;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   req_t  req;
   resp_t rsp;
   int    n_vec = 0;
   int    n_err = 0;

   axi_err_slv_term dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .slv_req_i  (req),
      .slv_resp_o (rsp)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int      good, lasts, bad, beats;
      logic    pv, pr;
      r_chan_t prev_r;
      b_chan_t prev_b;

      req = '0;
      step();
      chk("rst_aw_ready", rsp.aw_ready, 1);
      chk("rst_ar_ready", rsp.ar_ready, 1);
      chk("rst_others", {rsp.w_ready, rsp.b_valid, rsp.r_valid, rsp.b, rsp.r}, 0);
      rst = 1'b0;
      step();

      // single write
      req.aw_valid = 1; req.aw.id = 4'd3; req.aw.len = 8'd0;
      step();
      chk("sw_w_ready", rsp.w_ready, 1);
      chk("sw_aw_busy", rsp.aw_ready, 0);
      req.aw_valid = 0; req.w_valid = 1; req.w.last = 1; req.b_ready = 1;
      step();
      chk("sw_b", {rsp.b_valid, rsp.b.id, rsp.b.resp}, {1'b1, 4'd3, 2'b11});
      chk("sw_w_closed", rsp.w_ready, 0);
      req.w_valid = 0; req.w.last = 0;
      step();
      chk("sw_b_done", rsp.b_valid, 0);
      chk("sw_aw_ready", rsp.aw_ready, 1);

      // early W
      req.w_valid = 1; bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (rsp.w_ready !== 1'b0) bad++;
         step();
      end
      chk("ew_stall", bad, 0);
      req.aw_valid = 1; req.aw.id = 4'd1; req.aw.len = 8'd3;
      chk("ew_w_ready_pre", rsp.w_ready, 0);
      step();
      req.aw_valid = 0; good = 0;
      for (int i = 0; i < 4; i++) begin
         req.w.last = (i == 3);
         if (rsp.w_ready === 1'b1) good++;
         step();
      end
      chk("ew_beats", good, 4);
      chk("ew_b", {rsp.b_valid, rsp.b.id, rsp.b.resp}, {1'b1, 4'd1, 2'b11});
      req.w_valid = 0; req.w.last = 0;
      step();
      chk("ew_b_done", rsp.b_valid, 0);

      // long read
      req.ar_valid = 1; req.ar.id = 4'd7; req.ar.len = 8'd255; req.r_ready = 1;
      step();
      req.ar_valid = 0; good = 0; lasts = 0;
      for (int i = 0; i < 256; i++) begin
         if (rsp.r_valid === 1'b1 && rsp.r.id === 4'd7 && rsp.r.data === DATA_EXP &&
             rsp.r.resp === 2'b11 && rsp.r.last === (i == 255)) good++;
         if (rsp.r.last === 1'b1) lasts++;
         step();
      end
      chk("lr_beats", good, 256);
      chk("lr_lasts", lasts, 1);
      chk("lr_done", {rsp.r_valid, rsp.ar_ready}, 2'b01);

      // back-pressure read
      req.ar_valid = 1; req.ar.id = 4'd6; req.ar.len = 8'd2; req.r_ready = 0;
      step();
      req.ar_valid = 0; beats = 0; lasts = 0; bad = 0; pv = 0; pr = 0; prev_r = '0;
      for (int i = 0; i < 40; i++) begin
         if (pv && !pr && (rsp.r_valid !== 1'b1 || rsp.r !== prev_r)) bad++;
         req.r_ready = (i >= 30) ? 1'b1 : 1'($urandom_range(0, 1));
         if (rsp.r_valid && req.r_ready) begin
            beats++;
            if (rsp.r.last) lasts++;
         end
         pv = rsp.r_valid; pr = req.r_ready; prev_r = rsp.r;
         step();
      end
      chk("bp_r_stable", bad, 0);
      chk("bp_r_beats", beats, 3);
      chk("bp_r_lasts", lasts, 1);
      chk("bp_r_idle", {rsp.r_valid, rsp.ar_ready}, 2'b01);

      // back-pressure write
      req.r_ready = 0; req.b_ready = 0;
      req.aw_valid = 1; req.aw.id = 4'd9;
      step();
      req.aw_valid = 0; req.w_valid = 1; req.w.last = 1;
      step();
      req.w_valid = 0; req.w.last = 0; bad = 0; prev_b = rsp.b;
      chk("bp_b", {rsp.b_valid, rsp.b.id, rsp.b.resp}, {1'b1, 4'd9, 2'b11});
      for (int i = 0; i < 10; i++) begin
         step();
         if (rsp.b_valid !== 1'b1 || rsp.b !== prev_b || rsp.aw_ready !== 1'b0) bad++;
      end
      chk("bp_b_held", bad, 0);
      req.b_ready = 1;
      step();
      chk("bp_b_done", {rsp.b_valid, rsp.aw_ready}, 2'b01);

      // concurrent AW and AR
      req.aw_valid = 1; req.aw.id = 4'd2; req.ar_valid = 1; req.ar.id = 4'd5; req.ar.len = 8'd1;
      step();
      req.aw_valid = 0; req.ar_valid = 0;
      chk("cc_accept", {rsp.aw_ready, rsp.ar_ready, rsp.w_ready, rsp.r_valid}, 4'b0011);
      chk("cc_r0", {rsp.r.id, rsp.r.last}, {4'd5, 1'b0});
      req.w_valid = 1; req.w.last = 1; req.r_ready = 1;
      step();
      req.w_valid = 0; req.w.last = 0;
      chk("cc_b", {rsp.b_valid, rsp.b.id}, {1'b1, 4'd2});
      chk("cc_r1", {rsp.r_valid, rsp.r.id, rsp.r.last}, {1'b1, 4'd5, 1'b1});
      step();
      chk("cc_done", {rsp.b_valid, rsp.r_valid, rsp.aw_ready, rsp.ar_ready}, 4'b0011);

      // reset mid-burst
      req.ar_valid = 1; req.ar.id = 4'd3; req.ar.len = 8'd7;
      step();
      req.ar_valid = 0;
      step();
      chk("rm_mid", {rsp.r_valid, rsp.r.last}, 2'b10);
      rst = 1'b1;
      #1;
      chk("rm_async", {rsp.r_valid, rsp.ar_ready, rsp.aw_ready}, 3'b011);
      step();
      rst = 1'b0;
      req.ar_valid = 1; req.ar.id = 4'd4; req.ar.len = 8'd0;
      step();
      req.ar_valid = 0;
      chk("rm_r", {rsp.r_valid, rsp.r.id, rsp.r.last, rsp.r.resp}, {1'b1, 4'd4, 1'b1, 2'b11});
      step();
      chk("rm_done", {rsp.r_valid, rsp.ar_ready}, 2'b01);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
